// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control path.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_supported_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_mc_controller_aludec.sv
// ALU decoder: maps the controller's aluop class and the R-type funct field
// onto the 3-bit ALU control code. Unknown functs fall back to add.
module mc_aludec
    import mips_mc_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alucontrol_o
);

    // Combinational decode of aluop / funct.
    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_SUB:   alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_SUB:  alucontrol_o = ALU_SUB;
                    FN_AND:  alucontrol_o = ALU_AND;
                    FN_OR:   alucontrol_o = ALU_OR;
                    FN_SLT:  alucontrol_o = ALU_SLT;
                    default: alucontrol_o = ALU_ADD;
                endcase
            end
            default:     alucontrol_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM. Moore outputs per state; pcen also depends on
// the ALU zero flag, and the FETCH/MEMRD/MEMWR waits depend on mem_ready.
//
//  state   | meaning
//  FETCH   | read instr at PC, PC <= PC+4 when memory ready
//  DECODE  | read regs, branch target into ALUOut
//  MEMADR  | compute load/store address
//  MEMRD   | load data read, wait for memory
//  MEMWB   | write loaded data to rt
//  MEMWR   | store, strobe held until memory ready
//  RTYPEEX | R-type ALU operation
//  RTYPEWB | write ALUOut to rd
//  BEQEX   | compare, branch if zero
//  ADDIEX  | rs + signimm
//  ADDIWB  | write ALUOut to rt
//  JEX     | load jump target into PC
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pcen_o,
    output logic       memwrite_o,
    output logic       irwrite_o,
    output logic       regwrite_o,
    output logic       iord_o,
    output logic       memtoreg_o,
    output logic       regdst_o,
    output logic       alusrca_o,
    output logic [1:0] alusrcb_o,
    output logic [1:0] pcsrc_o,
    output logic [2:0] alucontrol_o,
    output logic       illegal_op_o
);

    state_t     state_q, state_d;
    logic       ready;
    logic       pcwrite, branch, alu_en;
    logic [1:0] aluop;
    logic [2:0] alu_dec;

    assign ready = USE_MEM_READY ? mem_ready_i : 1'b1;

    // State register, asynchronously forced to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state selection.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Output decode; everything held low while reset is high or in an unused encoding.
    always_comb begin
        pcwrite      = 1'b0;
        branch       = 1'b0;
        memwrite_o   = 1'b0;
        irwrite_o    = 1'b0;
        regwrite_o   = 1'b0;
        iord_o       = 1'b0;
        memtoreg_o   = 1'b0;
        regdst_o     = 1'b0;
        alusrca_o    = 1'b0;
        alusrcb_o    = SRCB_RD2;
        pcsrc_o      = PCSRC_ALU;
        illegal_op_o = 1'b0;
        aluop        = ALUOP_ADD;
        alu_en       = 1'b1;
        if (reset) begin
            alu_en = 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    alusrcb_o = SRCB_FOUR;
                    irwrite_o = ready;
                    pcwrite   = ready;
                end
                S_DECODE: begin
                    alusrcb_o    = SRCB_IMMSH2;
                    illegal_op_o = !is_supported_op(op_i);
                end
                S_MEMADR, S_ADDIEX: begin
                    alusrca_o = 1'b1;
                    alusrcb_o = SRCB_IMM;
                end
                S_MEMRD:  iord_o = 1'b1;
                S_MEMWB: begin
                    memtoreg_o = 1'b1;
                    regwrite_o = 1'b1;
                end
                S_MEMWR: begin
                    iord_o     = 1'b1;
                    memwrite_o = 1'b1;
                end
                S_RTYPEEX: begin
                    alusrca_o = 1'b1;
                    aluop     = ALUOP_FUNCT;
                end
                S_RTYPEWB: begin
                    regdst_o   = 1'b1;
                    regwrite_o = 1'b1;
                end
                S_BEQEX: begin
                    alusrca_o = 1'b1;
                    aluop     = ALUOP_SUB;
                    pcsrc_o   = PCSRC_ALUOUT;
                    branch    = 1'b1;
                end
                S_ADDIWB: regwrite_o = 1'b1;
                S_JEX: begin
                    pcsrc_o = PCSRC_JUMP;
                    pcwrite = 1'b1;
                end
                default:  alu_en = 1'b0;
            endcase
        end
    end

    mc_aludec u_aludec (
        .aluop_i      (aluop),
        .funct_i      (funct_i),
        .alucontrol_o (alu_dec)
    );

    assign alucontrol_o = alu_en ? alu_dec : 3'b000;
    assign pcen_o       = pcwrite | (branch & zero_i);

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: an instruction-level model expands each
// instruction into the per-cycle control words it should produce.
module tb_mips_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0, funct = 6'd0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca, illegal_op;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [15:0] outv;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        rdy;
        logic [15:0] exp;
    } step_t;
    step_t q[$];

    always #5 clk = ~clk;

    mips_mc_controller dut (
        .clk(clk), .reset(reset), .op_i(op), .funct_i(funct), .zero_i(zero),
        .mem_ready_i(mem_ready), .pcen_o(pcen), .memwrite_o(memwrite), .irwrite_o(irwrite),
        .regwrite_o(regwrite), .iord_o(iord), .memtoreg_o(memtoreg), .regdst_o(regdst),
        .alusrca_o(alusrca), .alusrcb_o(alusrcb), .pcsrc_o(pcsrc),
        .alucontrol_o(alucontrol), .illegal_op_o(illegal_op)
    );

    assign outv = {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                   alusrcb, pcsrc, alucontrol, illegal_op};

    function automatic logic [15:0] mk(input logic pe, mw, irw, rw, io, m2r, rd, sa,
                                       input logic [1:0] sb, ps, input logic [2:0] alu,
                                       input logic ill);
        return {pe, mw, irw, rw, io, m2r, rd, sa, sb, ps, alu, ill};
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic rnd_bit();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic r, input logic [15:0] e);
        step_t s;
        s.rdy = r;
        s.exp = e;
        q.push_back(s);
    endtask

    // Expands one instruction (with fw fetch wait cycles, mw memory wait cycles)
    // into expected control words; ends with one not-ready FETCH cycle.
    task automatic model_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                               input int fw, input int mw);
        logic [15:0] fetch_wait;
        fetch_wait = mk(0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
        for (int i = 0; i < fw; i++) push(1'b0, fetch_wait);
        push(1'b1, mk(1,0,1,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0));
        push(rnd_bit(), mk(0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010,
             !(o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
               o == 6'b000100 || o == 6'b001000 || o == 6'b000010)));
        case (o)
            6'b100011: begin
                push(rnd_bit(), mk(0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0));
                for (int i = 0; i < mw; i++) push(1'b0, mk(0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b010, 0));
                push(1'b1, mk(0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b010, 0));
                push(rnd_bit(), mk(0,0,0,1,0,1,0,0, 2'b00, 2'b00, 3'b010, 0));
            end
            6'b101011: begin
                push(rnd_bit(), mk(0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0));
                for (int i = 0; i < mw; i++) push(1'b0, mk(0,1,0,0,1,0,0,0, 2'b00, 2'b00, 3'b010, 0));
                push(1'b1, mk(0,1,0,0,1,0,0,0, 2'b00, 2'b00, 3'b010, 0));
            end
            6'b000000: begin
                push(rnd_bit(), mk(0,0,0,0,0,0,0,1, 2'b00, 2'b00, rtype_alu(f), 0));
                push(rnd_bit(), mk(0,0,0,1,0,0,1,0, 2'b00, 2'b00, 3'b010, 0));
            end
            6'b000100: push(rnd_bit(), mk(z,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b110, 0));
            6'b001000: begin
                push(rnd_bit(), mk(0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0));
                push(rnd_bit(), mk(0,0,0,1,0,0,0,0, 2'b00, 2'b00, 3'b010, 0));
            end
            6'b000010: push(rnd_bit(), mk(1,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b010, 0));
            default: ;
        endcase
        push(1'b0, fetch_wait);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (outv !== 16'h0) begin errors++; $display("FAIL reset_hold: got %h want %h", outv, 16'h0); end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (outv !== 16'h0) begin errors++; $display("FAIL reset_edge: got %h want %h", outv, 16'h0); end
        mem_ready = 1'b0;
        @(negedge clk); reset = 1'b0; #1;
        checks++;
        if (outv !== mk(0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0)) begin
            errors++; $display("FAIL reset_fetch: got %h want %h", outv,
                               mk(0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        op = 6'b100011; funct = 6'd0; zero = 1'b0;
        q.delete(); model_instr(op, funct, zero, 0, 0);
        foreach (q[i]) begin
            mem_ready = q[i].rdy; #1; checks++;
            if (outv !== q[i].exp) begin errors++; $display("FAIL lw step %0d: got %h want %h", i, outv, q[i].exp); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        for (int k = 0; k < 2; k++) begin
            op = 6'b000000; funct = (k == 0) ? 6'b100000 : 6'b100010;
            q.delete(); model_instr(op, funct, zero, 0, 0);
            foreach (q[i]) begin
                mem_ready = q[i].rdy; #1; checks++;
                if (outv !== q[i].exp) begin errors++; $display("FAIL rtype%0d step %0d: got %h want %h", k, i, outv, q[i].exp); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_beq();
        for (int k = 0; k < 2; k++) begin
            op = 6'b000100; zero = (k == 0);
            q.delete(); model_instr(op, funct, zero, 0, 0);
            foreach (q[i]) begin
                mem_ready = q[i].rdy; #1; checks++;
                if (outv !== q[i].exp) begin errors++; $display("FAIL beq_z%0d step %0d: got %h want %h", zero, i, outv, q[i].exp); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_sw_wait();
        op = 6'b101011; zero = 1'b0;
        q.delete(); model_instr(op, funct, zero, 1, 3);
        foreach (q[i]) begin
            mem_ready = q[i].rdy; #1; checks++;
            if (outv !== q[i].exp) begin errors++; $display("FAIL sw_wait step %0d: got %h want %h", i, outv, q[i].exp); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] memrd_exp;
        op = 6'b100011;
        q.delete(); model_instr(op, funct, zero, 0, 0);
        for (int i = 0; i < 3; i++) begin
            mem_ready = q[i].rdy; #1; checks++;
            if (outv !== q[i].exp) begin errors++; $display("FAIL arst_pre step %0d: got %h want %h", i, outv, q[i].exp); end
            @(posedge clk); #1;
        end
        memrd_exp = mk(0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b010, 0);
        mem_ready = 1'b0; #1; checks++;
        if (outv !== memrd_exp) begin errors++; $display("FAIL arst_memrd: got %h want %h", outv, memrd_exp); end
        #1 reset = 1'b1; mem_ready = 1'b1; #1; checks++;
        if (outv !== 16'h0) begin errors++; $display("FAIL arst_now: got %h want %h", outv, 16'h0); end
        @(posedge clk); #1; checks++;
        if (outv !== 16'h0) begin errors++; $display("FAIL arst_held: got %h want %h", outv, 16'h0); end
        mem_ready = 1'b0;
        @(negedge clk); reset = 1'b0; #1; checks++;
        if (outv !== q[q.size()-1].exp) begin
            errors++; $display("FAIL arst_fetch: got %h want %h", outv, q[q.size()-1].exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        op = 6'b111111;
        q.delete(); model_instr(op, funct, zero, 0, 0);
        foreach (q[i]) begin
            mem_ready = q[i].rdy; #1; checks++;
            if (outv !== q[i].exp) begin errors++; $display("FAIL illegal step %0d: got %h want %h", i, outv, q[i].exp); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[7];
        logic [5:0] fns[6];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        for (int n = 0; n < 40; n++) begin
            op    = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            funct = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            zero  = rnd_bit();
            q.delete();
            model_instr(op, funct, zero, $urandom_range(0, 2), $urandom_range(0, 3));
            foreach (q[i]) begin
                mem_ready = q[i].rdy; #1; checks++;
                if (outv !== q[i].exp) begin
                    errors++; $display("FAIL rand%0d op=%b fn=%b step %0d: got %h want %h",
                                       n, op, funct, i, outv, q[i].exp);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_sw_wait();
        test_async_reset();
        test_illegal();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
